// File: rtl/apb_timer_ctrl_pkg.sv
// Shared definitions for the APB timer control slave: FSM states, register map
// and the address decode check.
package apb_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [11:0] ADDR_TCR   = 12'h000;
  localparam logic [11:0] ADDR_TDR0  = 12'h004;
  localparam logic [11:0] ADDR_TDR1  = 12'h008;
  localparam logic [11:0] ADDR_TCMP0 = 12'h00C;
  localparam logic [11:0] ADDR_TCMP1 = 12'h010;
  localparam logic [11:0] ADDR_TIER  = 12'h014;
  localparam logic [11:0] ADDR_TISR  = 12'h018;
  localparam logic [11:0] ADDR_THCSR = 12'h01C;
  localparam logic [11:0] ADDR_MAX   = 12'h01C;

  // Word-aligned addresses up to the last register are legal.
  function automatic logic addr_decode_err(input logic [11:0] addr);
    return (addr[1:0] != 2'b00) || (addr > ADDR_MAX);
  endfunction

endpackage

// File: rtl/apb_timer_ctrl.sv
// APB slave front end for the timer register file: latches the setup phase,
// inserts WAIT_CYCLES wait states and issues one-cycle register commits.
module apb_timer_ctrl
  import apb_timer_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [11:0] paddr,
  input  logic [31:0] pwdata,
  input  logic [3:0]  pstrb,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic [11:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_strb,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [31:0] reg_rdata,
  input  logic        reg_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e     state;
  logic [3:0] wait_cnt;
  logic       lat_write;
  logic       access;
  logic       decode_err;

  // Completion is decoded from the registered state and the live psel/penable
  // so pready can fall in the same cycle the master withdraws the transfer.
  always_comb begin
    access     = (state == ACCESS) && psel && penable;
    decode_err = addr_decode_err(reg_addr);
    pready     = access;
    reg_wr_en  = access && lat_write && !decode_err && !reg_err;
    reg_rd_en  = access && !lat_write && !decode_err;
    pslverr    = access && (decode_err || (lat_write && reg_err));
    prdata     = reg_rd_en ? reg_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_write <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_strb  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            reg_addr  <= paddr;
            reg_wdata <= pwdata;
            reg_strb  <= pstrb;
            lat_write <= pwrite;
            if (WAIT_CYCLES > 0) begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else if (wait_cnt == 4'd0) begin
            state <= ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACCESS: begin
          // A back-to-back setup phase is picked up from IDLE on the next cycle.
          if (!psel || access) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_timer_ctrl.sv
// Scoreboard bench for apb_timer_ctrl: three instances with 0, 2 and 3 wait
// states, directed transfers with hand-computed responses.
module tb_apb_timer_ctrl;

  typedef struct {
    int          d;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] prdata;
    logic        slverr;
    logic        wr;
    logic        rd;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel      [3];
  logic        penable   [3];
  logic        pwrite    [3];
  logic [11:0] paddr     [3];
  logic [31:0] pwdata    [3];
  logic [3:0]  pstrb     [3];
  logic        pready    [3];
  logic [31:0] prdata    [3];
  logic        pslverr   [3];
  logic [11:0] reg_addr  [3];
  logic [31:0] reg_wdata [3];
  logic [3:0]  reg_strb  [3];
  logic        reg_wr_en [3];
  logic        reg_rd_en [3];
  logic [31:0] reg_rdata [3];
  logic        reg_err   [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t_setup [3] = '{0, 0, 0};
  int   wr_cnt  [3] = '{0, 0, 0};
  exp_t sb[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_timer_ctrl #(.WAIT_CYCLES(g == 0 ? 0 : g + 1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .psel      (psel[g]),
      .penable   (penable[g]),
      .pwrite    (pwrite[g]),
      .paddr     (paddr[g]),
      .pwdata    (pwdata[g]),
      .pstrb     (pstrb[g]),
      .pready    (pready[g]),
      .prdata    (prdata[g]),
      .pslverr   (pslverr[g]),
      .reg_addr  (reg_addr[g]),
      .reg_wdata (reg_wdata[g]),
      .reg_strb  (reg_strb[g]),
      .reg_wr_en (reg_wr_en[g]),
      .reg_rd_en (reg_rd_en[g]),
      .reg_rdata (reg_rdata[g]),
      .reg_err   (reg_err[g])
    );
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per pready, otherwise requires quiet outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int d = 0; d < 3; d++) begin
          if (reg_wr_en[d] === 1'b1) wr_cnt[d]++;
          if (pready[d] === 1'b1) begin
            if (sb.size() == 0 || sb[0].d != d) begin
              checks++;
              errors++;
              $display("FAIL dut%0d_unexpected_pready act=1 exp=0", d);
            end else begin
              e = sb.pop_front();
              chk($sformatf("dut%0d_prdata", d),    prdata[d],    e.prdata);
              chk($sformatf("dut%0d_pslverr", d),   pslverr[d],   e.slverr);
              chk($sformatf("dut%0d_reg_wr_en", d), reg_wr_en[d], e.wr);
              chk($sformatf("dut%0d_reg_rd_en", d), reg_rd_en[d], e.rd);
              chk($sformatf("dut%0d_reg_addr", d),  reg_addr[d],  e.addr);
              chk($sformatf("dut%0d_reg_wdata", d), reg_wdata[d], e.wdata);
              chk($sformatf("dut%0d_reg_strb", d),  reg_strb[d],  e.strb);
              chk($sformatf("dut%0d_latency", d),   32'(cyc - t_setup[d] + 1), 32'(e.lat));
            end
          end else begin
            chk($sformatf("dut%0d_idle_outputs", d),
                {prdata[d] != 0, pslverr[d], reg_wr_en[d], reg_rd_en[d]}, 32'h0);
          end
        end
      end
    end
  end

  task automatic wait_ready(input int d);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (pready[d] === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL dut%0d_timeout act=no_pready exp=pready", d);
    sb.delete();
  endtask

  task automatic xfer(input int d, input logic wr, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] rdata, input logic err,
                      input logic [31:0] e_prdata, input logic e_slverr,
                      input logic e_wr, input logic e_rd, input int e_lat);
    exp_t e;
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = addr; pwdata[d] = wdata; pstrb[d] = strb;
    reg_rdata[d] = rdata; reg_err[d] = err;
    e = '{d, addr, wdata, strb, e_prdata, e_slverr, e_wr, e_rd, e_lat};
    sb.push_back(e);
    @(posedge clk); #1;
    penable[d] = 1'b1;
    t_setup[d] = cyc;
    paddr[d] = ~addr; pwdata[d] = ~wdata; pstrb[d] = ~strb;
    wait_ready(d);
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic chk_zero(input int d, input string tag);
    chk($sformatf("dut%0d_%s_pready", d, tag),    pready[d],    32'h0);
    chk($sformatf("dut%0d_%s_prdata", d, tag),    prdata[d],    32'h0);
    chk($sformatf("dut%0d_%s_pslverr", d, tag),   pslverr[d],   32'h0);
    chk($sformatf("dut%0d_%s_reg_wr_en", d, tag), reg_wr_en[d], 32'h0);
    chk($sformatf("dut%0d_%s_reg_rd_en", d, tag), reg_rd_en[d], 32'h0);
    chk($sformatf("dut%0d_%s_reg_addr", d, tag),  reg_addr[d],  32'h0);
    chk($sformatf("dut%0d_%s_reg_wdata", d, tag), reg_wdata[d], 32'h0);
    chk($sformatf("dut%0d_%s_reg_strb", d, tag),  reg_strb[d],  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
      reg_rdata[d] = 32'h5A5A_5A5A; reg_err[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_zero(d, "reset");
    rst_n = 1'b1;

    // No wait states
    xfer(0, 1'b1, 12'h000, 32'h0000_0003, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1); idle(0);
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1); idle(0);
    xfer(0, 1'b1, 12'h002, 32'hAAAA_0001, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1); idle(0);
    xfer(0, 1'b1, 12'h020, 32'hAAAA_0002, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1); idle(0);
    xfer(0, 1'b0, 12'h01C, 32'h0, 4'h0, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b1, 1); idle(0);
    xfer(0, 1'b0, 12'h019, 32'h0, 4'h0, 32'h0000_0055, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1); idle(0);
    xfer(0, 1'b0, 12'h020, 32'h0, 4'h0, 32'h0000_0066, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1); idle(0);
    // reg_err on a write, then back-to-back read with no idle cycle between
    xfer(0, 1'b1, 12'h000, 32'h0000_FFFF, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, 1);
    xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b1, 1); idle(0);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 32'h0BAD_BEEF, 1'b1, 32'h0BAD_BEEF, 1'b0, 1'b0, 1'b1, 1); idle(0);
    chk("dut0_wr_count", 32'(wr_cnt[0]), 32'd1);

    // penable without a setup phase is ignored
    n = wr_cnt[0];
    @(posedge clk); #1;
    psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 12'h010;
    repeat (4) @(posedge clk);
    #1;
    chk("dut0_no_setup_wr_count", 32'(wr_cnt[0]), 32'(n));
    psel[0] = 1'b0; penable[0] = 1'b0;

    // Two wait states
    xfer(1, 1'b0, 12'h00C, 32'h0, 4'h0, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 3); idle(1);
    xfer(1, 1'b1, 12'h014, 32'hDEAD_BEEF, 4'h5, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3); idle(1);
    chk("dut1_wr_count", 32'(wr_cnt[1]), 32'd1);

    // Three wait states: psel dropped in the second wait cycle
    n = wr_cnt[2];
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 12'h010; pwdata[2] = 32'h1111_1111; pstrb[2] = 4'hF; reg_err[2] = 1'b0;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    @(posedge clk); #1;
    psel[2] = 1'b0; penable[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("dut2_abort_wr_count", 32'(wr_cnt[2]), 32'(n));
    xfer(2, 1'b1, 12'h018, 32'h8765_4321, 4'hF, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4); idle(2);
    chk("dut2_after_abort_wr_count", 32'(wr_cnt[2]), 32'(n + 1));

    // Reset asserted during a wait cycle
    n = wr_cnt[2];
    @(posedge clk); #1;
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 12'h00C; pwdata[2] = 32'h2222_2222; pstrb[2] = 4'hF;
    @(posedge clk); #1;
    penable[2] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk_zero(d, "midreset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("dut2_post_reset_wr_count", 32'(wr_cnt[2]), 32'(n));
    chk("dut2_post_reset_reg_addr", reg_addr[2], 32'h0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    xfer(2, 1'b1, 12'h010, 32'h3333_3333, 4'h3, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 4); idle(2);
    chk("dut2_final_wr_count", 32'(wr_cnt[2]), 32'(n + 1));

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_timer_ctrl.md
APB_TIMER_CTRL -- requirements
Module: apb_timer_ctrl

Interface
REQ-001 The block SHALL have one parameter: WAIT_CYCLES, default 0, number of APB wait states inserted before pready (legal range 0..15).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  12  APB byte address.
- pwdata  in  32  APB write data.
- pstrb  in  4  APB byte strobes.
- pready  out  1  transfer complete.
- prdata  out  32  read data.
- pslverr  out  1  transfer error.
- reg_addr  out  12  latched address to the register file.
- reg_wdata  out  32  latched write data.
- reg_strb  out  4  latched strobes.
- reg_wr_en  out  1  one-cycle write commit.
- reg_rd_en  out  1  read enable.
- reg_rdata  in  32  register file read data (combinational).
- reg_err  in  1  register file write error (combinational on reg_* signals).

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, WAIT and ACCESS.
REQ-004 In IDLE, a cycle with psel=1 and penable=0 (setup phase) SHALL latch paddr, pwdata, pstrb and pwrite at the clock edge.
- The next state SHALL be WAIT if WAIT_CYCLES>0, otherwise ACCESS.
REQ-005 Entry to WAIT SHALL load a 4-bit wait counter with WAIT_CYCLES-1.
- Each WAIT cycle SHALL decrement the counter.
- Counter equal to 0 SHALL move the FSM to ACCESS on the next edge.
REQ-006 In WAIT or ACCESS, psel=0 SHALL abort the transfer: next state IDLE, no reg_wr_en pulse, pready=0.
REQ-007 pready SHALL be 1 only when state=ACCESS and psel=1 and penable=1; it SHALL be 0 otherwise.
REQ-008 decode_err SHALL be 1 when latched addr[1:0]≠0 or latched addr>12'h1C.
REQ-009 reg_wr_en SHALL be 1 only when pready=1 and latched pwrite=1 and decode_err=0 and reg_err=0.
- It SHALL be exactly one cycle per transfer.
REQ-010 reg_rd_en SHALL be 1 only when pready=1 and latched pwrite=0 and decode_err=0.
REQ-011 prdata SHALL equal reg_rdata when reg_rd_en=1, and 32'h0 otherwise.
REQ-012 pslverr SHALL be 1 only when pready=1 and (decode_err, or latched pwrite=1 with reg_err=1).
REQ-013 Leaving ACCESS after pready:
- psel=1 and penable=0 on the next cycle SHALL be treated as a new setup phase (back-to-back transfer, latch per REQ-004).
- Otherwise the FSM SHALL return to IDLE.
REQ-014 While pready=0, reg_addr, reg_wdata and reg_strb SHALL hold their latched values; pwdata and paddr changes during WAIT or ACCESS SHALL be ignored.
REQ-015 penable=1 observed in IDLE without a preceding setup phase SHALL be ignored: state stays IDLE and all outputs are 0.
REQ-016 Read latency SHALL be 1+WAIT_CYCLES cycles after the setup phase; write latency SHALL be the same.

Reset
REQ-017 On rst_n=0, asynchronously and at any point of a transfer:
- state SHALL be IDLE and the wait counter 0.
- reg_addr, reg_wdata and reg_strb SHALL be 0.
- pready, pslverr, prdata, reg_wr_en and reg_rd_en SHALL be 0.
REQ-018 A reset asserted mid-transfer SHALL discard that transfer; no commit SHALL occur after reset release.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state enumeration (IDLE, WAIT, ACCESS);
- the register address constants 12'h00..12'h1C (TCR, TDR0, TDR1, TCMP0, TCMP1, TIER, TISR, THCSR);
- the ADDR_MAX constant 12'h1C.
REQ-020 The block SHALL be a single module with no sub-modules; the wait counter SHALL be inline.

Verification
REQ-021 WAIT_CYCLES=0, write 32'h0000_0003 to 12'h00 with pstrb=4'hF -> pready in the first access cycle, one reg_wr_en pulse, pslverr=0.
REQ-022 WAIT_CYCLES=2, read 12'h0C with reg_rdata=32'hFFFF_FFFF -> pready on the 3rd access cycle, prdata=32'hFFFF_FFFF only in that cycle, 0 elsewhere.
REQ-023 Write to 12'h02 (misaligned) and to 12'h20 (out of range) -> pready=1, pslverr=1, reg_wr_en never asserted.
REQ-024 Write to 12'h00 with reg_err forced to 1 -> pslverr=1, reg_wr_en=0; then a back-to-back read of 12'h04 -> second transfer completes with pslverr=0.
REQ-025 WAIT_CYCLES=3, drop psel in the 2nd WAIT cycle -> FSM returns to IDLE, no reg_wr_en, a following normal write commits correctly.
REQ-026 Assert rst_n=0 during WAIT -> all outputs 0 immediately, no commit after release.
